// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed 7-segment scanner with frame snapshots, guard-band
// anti-ghosting, leading-zero blanking and registered active-low outputs.
module seven_seg_scanner #(
  parameter int DWELL = 50000,
  parameter int GUARD = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_BCD,
  input  logic [3:0]  i_dp,
  input  logic        i_blank_lz,
  output logic [3:0]  o_anode,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic        o_frame_done
);

  localparam int CW = $clog2(DWELL);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);

  typedef enum logic {ST_SNAP, ST_SCAN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     bcd_q;
  logic [3:0]      dp_q;
  logic            blz_q;
  logic [3:0]      anode_q, anode_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_out_q, dp_out_d;
  logic            done_q;

  logic            snap;
  logic            slot_end;
  logic [3:0][3:0] digits;
  logic [3:0]      blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // ST_SNAP is the single cycle after reset: take the first frame, hold the scan at 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_SNAP;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SNAP: state_d = ST_SCAN;
      default: state_d = ST_SCAN;
    endcase
  end

  assign slot_end = (cnt_q == CNT_LAST);

  always_comb begin
    snap = 1'b0;
    if (state_q == ST_SNAP)            snap = 1'b1;
    else if (slot_end && idx_q == 2'd3) snap = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (state_q == ST_SNAP) begin
      cnt_d = '0;
      idx_d = 2'd0;
    end else if (slot_end) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Frame registers: inputs are only sampled here, so a frame is never torn.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bcd_q <= '0;
      dp_q  <= '0;
      blz_q <= 1'b0;
    end else if (snap) begin
      bcd_q <= i_BCD;
      dp_q  <= i_dp;
      blz_q <= i_blank_lz;
    end
  end

  assign digits = bcd_q;

  always_comb begin
    blank    = '0;
    blank[3] = blz_q && (digits[3] == 4'd0);
    blank[2] = blank[3] && (digits[2] == 4'd0);
    blank[1] = blank[2] && (digits[1] == 4'd0);
  end

  always_comb begin
    anode_d  = 4'b1111;
    seg_d    = 7'b1111111;
    dp_out_d = 1'b1;
    if (state_q == ST_SCAN && cnt_q >= CNT_GUARD && !blank[idx_q]) begin
      anode_d  = ~(4'b0001 << idx_q);
      seg_d    = seg_decode(digits[idx_q]);
      dp_out_d = ~dp_q[idx_q];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      anode_q  <= 4'b1111;
      seg_q    <= 7'b1111111;
      dp_out_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      anode_q  <= anode_d;
      seg_q    <= seg_d;
      dp_out_q <= dp_out_d;
      done_q   <= snap;
    end
  end

  assign o_anode      = anode_q;
  assign o_seg        = seg_q;
  assign o_dp         = dp_out_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with DWELL=8, GUARD=2.
module tb_seven_seg_scanner;

  localparam int DWELL = 8;
  localparam int GUARD = 2;
  localparam logic [15:0] AN_ALL = 16'h7BDE;
  localparam logic [6:0]  OFF    = 7'h7F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd = 16'h1234;
  logic [3:0]  dpi = 4'b1111;
  logic        blz = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        fdone;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    logic [15:0]     bcd;
    logic [3:0]      dpi;
    logic            blz;
    logic [3:0][3:0] an;
    logic [3:0][6:0] seg;
    logic [3:0]      dpo;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  vec_t tv [8];
  exp_t sbq [$];

  seven_seg_scanner #(.DWELL(DWELL), .GUARD(GUARD)) dut (
    .i_clk(clk), .i_rst(rst), .i_BCD(bcd), .i_dp(dpi), .i_blank_lz(blz),
    .o_anode(anode), .o_seg(seg), .o_dp(dp), .o_frame_done(fdone)
  );

  always #5 clk = ~clk;

  // At most one digit may ever be lit.
  always @(negedge clk) begin
    nchk++;
    if ($countones(~anode) > 1) begin
      nerr++;
      $display("FAIL onehot_anode: got %b required at most one low bit", anode);
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_anode"}, {12'h0, anode}, 16'h000F);
    chk({tag, "_seg"},   {9'h0, seg},    16'h007F);
    chk({tag, "_dp"},    {15'h0, dp},    16'h0001);
    chk({tag, "_fd"},    {15'h0, fdone}, 16'h0000);
  endtask

  task automatic apply(input int i);
    bcd = tv[i].bcd;
    dpi = tv[i].dpi;
    blz = tv[i].blz;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1 chk_reset_outs("rst_async");
    repeat (2) @(posedge clk);
    #1 chk_reset_outs("rst_hold");
  endtask

  // Release reset with vector ia, optionally switch inputs to ib after edge chg,
  // and check nj output cycles. Output j>=2 shows scan count j-2.
  task automatic run_seq(input int ia, input int ib, input int chg, input int nj);
    exp_t e, a;
    int   c, slot, cnt, f;
    apply(ia);
    @(negedge clk) rst = 1'b0;
    for (int j = 1; j <= nj; j++) begin
      f = (j <= 33) ? ia : ((chg > 0 && chg < 33) ? ib : ia);
      e.fd = (j == 1 || j == 33 || j == 65);
      if (j == 1) begin
        e.an = 4'hF; e.seg = OFF; e.dp = 1'b1;
      end else begin
        c    = j - 2;
        slot = (c / DWELL) % 4;
        cnt  = c % DWELL;
        if (cnt < GUARD) begin
          e.an = 4'hF; e.seg = OFF; e.dp = 1'b1;
        end else begin
          e.an = tv[f].an[slot]; e.seg = tv[f].seg[slot]; e.dp = tv[f].dpo[slot];
        end
      end
      sbq.push_back(e);
      @(posedge clk);
      #1;
      a = sbq.pop_front();
      chk($sformatf("v%0d_j%0d_anode", ia, j), {12'h0, anode}, {12'h0, a.an});
      chk($sformatf("v%0d_j%0d_seg", ia, j),   {9'h0, seg},    {9'h0, a.seg});
      chk($sformatf("v%0d_j%0d_dp", ia, j),    {15'h0, dp},    {15'h0, a.dp});
      chk($sformatf("v%0d_j%0d_fd", ia, j),    {15'h0, fdone}, {15'h0, a.fd});
      if (j == chg) apply(ib);
    end
  endtask

  initial begin
    // {bcd, dp in, blank_lz, anode{s3..s0}, seg{s3..s0}, dp out{s3..s0}}
    tv[0] = '{16'h1234, 4'b0000, 1'b0, AN_ALL,
              {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111};
    tv[1] = '{16'h0070, 4'b0000, 1'b1, {4'b1111, 4'b1111, 4'b1101, 4'b1110},
              {OFF, OFF, 7'b1111000, 7'b1000000}, 4'b1111};
    tv[2] = '{16'h0070, 4'b0000, 1'b0, AN_ALL,
              {7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000}, 4'b1111};
    tv[3] = '{16'h00A0, 4'b0100, 1'b0, AN_ALL,
              {7'b1000000, 7'b1000000, 7'b0111111, 7'b1000000}, 4'b1011};
    tv[4] = '{16'h0000, 4'b0000, 1'b1, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
              {OFF, OFF, OFF, 7'b1000000}, 4'b1111};
    tv[5] = '{16'h9F05, 4'b1001, 1'b1, AN_ALL,
              {7'b0010000, 7'b0111111, 7'b1000000, 7'b0010010}, 4'b0110};
    tv[6] = '{16'h0805, 4'b1111, 1'b1, {4'b1111, 4'b1011, 4'b1101, 4'b1110},
              {OFF, 7'b0000000, 7'b1000000, 7'b0010010}, 4'b1000};
    tv[7] = '{16'h5678, 4'b0000, 1'b0, AN_ALL,
              {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}, 4'b1111};

    repeat (2) @(posedge clk);
    #1 chk_reset_outs("rst_init");

    for (int i = 0; i < 7; i++) begin
      run_seq(i, i, 0, 65);
      do_reset();
    end

    // Input change while slot 1 is lit must not reach the display until the next frame.
    run_seq(0, 7, 12, 65);
    do_reset();

    // Async reset at idx=2, cnt=5, then restart with a new snapshot.
    run_seq(0, 0, 0, 22);
    #2 rst = 1'b1;
    #1 chk_reset_outs("rst_midslot");
    repeat (2) @(posedge clk);
    run_seq(1, 1, 0, 33);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter DWELL, default 50000, clock cycles each digit slot is held; legal range 4..2^20.
REQ-002 Parameter GUARD, default 16, anti-ghosting cycles at the start of each slot with all anodes off; legal range 1..DWELL-2.
REQ-003 Port i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port i_rst  input  1  reset, asynchronous and active-high.
REQ-005 Port i_BCD  input  16  packed BCD {thousands, hundreds, tens, ones}, 4 bits per digit.
REQ-006 Port i_dp  input  4  decimal-point enables, active-high; bit n belongs to digit n.
REQ-007 Port i_blank_lz  input  1  leading-zero blanking enable.
REQ-008 Port o_anode  output  4  digit enables, active-low; bit 0 is the ones digit (rightmost).
REQ-009 Port o_seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 Port o_dp  output  1  decimal point, active-low.
REQ-011 Port o_frame_done  output  1  one-cycle pulse when a new frame snapshot is taken.

Function
REQ-012 The slot counter cnt SHALL count 0..DWELL-1 and wrap to 0; on that wrap, the digit index idx SHALL advance 0->1->2->3->0.
REQ-013 Frame snapshot: the block SHALL latch i_BCD, i_dp and i_blank_lz into internal frame registers on both of these events: (a) the first clock edge after reset deasserts; (b) the edge where cnt==DWELL-1 and idx==3.
REQ-014 o_frame_done SHALL be 1 for exactly the cycle following each snapshot edge, and 0 otherwise.
REQ-015 Inputs SHALL be ignored between snapshots, so the displayed value changes only at frame boundaries (no torn frames).
REQ-016 All outputs SHALL be registered and reflect the cnt/idx/frame state of the previous cycle (latency 1).
REQ-017 While cnt < GUARD: o_anode=4'b1111, o_seg=7'b1111111, o_dp=1.
REQ-018 While cnt >= GUARD and digit idx is not blanked: o_anode SHALL be 0 at bit idx only; o_seg SHALL be the decode of frame digit idx; o_dp SHALL be ~frame_dp[idx].
REQ-019 Decode table (active-low, {g..a}):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- 10..15 = 0111111 (dash; g only)
REQ-020 Blanking applies only when frame_blank_lz=1:
- digit 3 blanked if d3==0
- digit 2 blanked if d3==d2==0
- digit 1 blanked if d3==d2==d1==0
- digit 0 never blanked
REQ-021 A blanked slot SHALL drive o_anode=4'b1111, o_seg=7'b1111111, o_dp=1 for the whole slot.
REQ-022 The scan SHALL run freely; no handshake gates it, and the upstream BCD producer need not hold i_BCD stable except on the snapshot edge.

Reset
REQ-023 While i_rst=1, and immediately on its assertion: cnt=0, idx=0, frame registers=0, o_anode=4'b1111, o_seg=7'b1111111, o_dp=1, o_frame_done=0.
REQ-024 Reset asserted mid-slot or mid-frame SHALL abandon the scan; after release the scan restarts at idx=0, cnt=0 with a fresh snapshot per REQ-013a.

Verification (DWELL=8, GUARD=2)
REQ-025 Reset then release with i_BCD=16'h1234, i_blank_lz=0 -> o_frame_done pulses once one cycle after release; the ones slot shows o_anode=1110, o_seg=0011001 for 6 cycles after 2 dark cycles; subsequent slots show 3, 2, 1 on anodes 1101, 1011, 0111.
REQ-026 Change i_BCD from 16'h1234 to 16'h5678 mid-frame (idx=1) -> digits 2 and 3 still show 2 and 1; 5678 appears only after the next o_frame_done, which occurs 32 cycles after the previous one.
REQ-027 i_BCD=16'h0070, i_blank_lz=1 -> slots 3 and 2 fully dark (anode 1111); slot 1 shows 7 (1111000); slot 0 shows 0 (1000000). With i_blank_lz=0, slots 3 and 2 show 0.
REQ-028 i_BCD=16'h00A0, i_dp=4'b0100 -> slot 1 shows dash 0111111; o_dp=0 only during the active part of slot 2; never during the guard cycles.
REQ-029 Assert i_rst asynchronously at idx=2, cnt=5 -> outputs go to their reset values before the next clock edge; after release the scan restarts at idx=0 with a new snapshot.
REQ-030 Every cycle, check that at most one o_anode bit is 0 and that o_anode=1111 whenever cnt<GUARD.
